// File: rtl/fifo_read.sv
// Frame reader: pulls data_len bytes from a standard (non-FWFT) FIFO, checks them
// against a fixed index pattern, captures the part number and counts mismatches.
module fifo_read #(
  parameter int unsigned MAX_LEN = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_rxd,
  output logic        fifo_rxen,
  input  logic        fs,
  output logic        fd,
  input  logic [11:0] data_len,
  output logic [15:0] part,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [7:0]  so
);

  typedef enum logic [7:0] {
    IDLE = 8'b0000_0001,
    PREP = 8'b0000_0010,
    WORK = 8'b0000_0100,
    LAST = 8'b0000_1000
  } state_t;

  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  state_t      state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] rd_num_q, rd_num_d;
  logic [11:0] chk_num_q, chk_num_d;
  logic        rd_vld_q, rd_vld_d;
  logic [15:0] part_q, part_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [11:0] len_clip;
  logic        mismatch;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_num_d  = rd_num_q;
    chk_num_d = chk_num_q;
    part_d    = part_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    mismatch  = 1'b0;
    len_clip  = (data_len > MAX_LEN_W) ? MAX_LEN_W : data_len;

    // Combinational so a read can never be issued in a cycle the FIFO is empty.
    fifo_rxen = (state_q == WORK) && !fifo_empty && fs && (rd_num_q < len_q);
    rd_vld_d  = fifo_rxen;

    case (state_q)
      IDLE: begin
        if (fs) state_d = PREP;
      end
      PREP: begin
        len_d     = len_clip;
        rd_num_d  = '0;
        chk_num_d = '0;
        err_d     = 1'b0;
        err_cnt_d = '0;
        state_d   = (len_clip == 12'd0) ? LAST : WORK;
      end
      WORK: begin
        // Abort wins: the byte still in flight is dropped unchecked.
        if (!fs) begin
          state_d = IDLE;
        end else begin
          if (fifo_rxen) rd_num_d = rd_num_q + 12'd1;
          if (rd_vld_q) begin
            case (chk_num_q)
              12'd0:   mismatch = (fifo_rxd != 8'h66);
              12'd1:   mismatch = (fifo_rxd != 8'hBB);
              12'd2:   part_d[15:8] = fifo_rxd;
              12'd3:   part_d[7:0]  = fifo_rxd;
              default: mismatch = (fifo_rxd != chk_num_q[7:0]);
            endcase
            chk_num_d = chk_num_q + 12'd1;
          end
          if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
          if ((chk_num_q == len_q) && !rd_vld_q) state_d = LAST;
        end
      end
      LAST: begin
        if (!fs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rd_num_q  <= '0;
      chk_num_q <= '0;
      rd_vld_q  <= 1'b0;
      part_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_num_q  <= rd_num_d;
      chk_num_q <= chk_num_d;
      rd_vld_q  <= rd_vld_d;
      part_q    <= part_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign fd      = (state_q == LAST);
  assign part    = part_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign so      = chk_num_q[7:0];

endmodule

// File: tb/tb_fifo_read.sv
// Bench for fifo_read: emulates the source FIFO, tracks expected outputs with a
// frame-level model every cycle, and pins key frames with literal expectations.
module tb_fifo_read;
  localparam int unsigned MAXL = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_rxd;
  logic        fifo_rxen;
  logic        fs;
  logic        fd;
  logic [11:0] data_len;
  logic [15:0] part;
  logic        err;
  logic [7:0]  err_cnt;
  logic [7:0]  so;

  always #5 clk = ~clk;

  fifo_read #(.MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rxd(fifo_rxd),
    .fifo_rxen(fifo_rxen), .fs(fs), .fd(fd), .data_len(data_len),
    .part(part), .err(err), .err_cnt(err_cnt), .so(so)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // FIFO emulation
  logic [7:0] fq[$];
  logic [7:0] rxd_next = 8'h00;
  bit         tog_en = 1'b0;
  bit         tog = 1'b0;
  int         rxen_total = 0;
  bit         fd_seen = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    fifo_rxd   = rxd_next;
    tog        = ~tog;
    fifo_empty = (fq.size() == 0) || (tog_en && tog);
  end

  // Frame model: phase 0 idle, 1 length capture, 2 transfer, 3 done
  int         m_ph = 0, m_len = 0, m_reads = 0, m_chk = 0, m_cnt = 0, eb;
  bit         m_pend = 1'b0, m_err = 1'b0, rx_exp;
  logic [15:0] m_part = 16'h0000;

  function automatic int exp_byte(input int n);
    if (n == 0) return 'h66;
    if (n == 1) return 'hBB;
    return n % 256;
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_ph = 0; m_len = 0; m_reads = 0; m_chk = 0; m_cnt = 0;
      m_pend = 1'b0; m_err = 1'b0; m_part = 16'h0000;
    end else begin
      rx_exp = (m_ph == 2) && !fifo_empty && fs && (m_reads < m_len);
      check("cyc_rxen", int'(fifo_rxen), int'(rx_exp));
      check("cyc_fd", int'(fd), int'(m_ph == 3));
      check("cyc_err", int'(err), int'(m_err));
      check("cyc_err_cnt", int'(err_cnt), m_cnt);
      check("cyc_part", int'(part), int'(m_part));
      check("cyc_so", int'(so), m_chk % 256);
      if (fd) fd_seen = 1'b1;
      if (fifo_rxen) begin
        rxen_total++;
        if (fq.size() > 0) rxd_next = fq.pop_front();
        else check("fifo_underflow", 1, 0);
      end
      case (m_ph)
        0: if (fs) m_ph = 1;
        1: begin
          m_len = (int'(data_len) > MAXL) ? MAXL : int'(data_len);
          m_reads = 0; m_chk = 0; m_err = 1'b0; m_cnt = 0;
          m_ph = (m_len == 0) ? 3 : 2;
        end
        2: begin
          if (!fs) m_ph = 0;
          else begin
            if (m_chk == m_len && !m_pend) m_ph = 3;
            if (m_pend) begin
              if (m_chk == 2) m_part[15:8] = fifo_rxd;
              else if (m_chk == 3) m_part[7:0] = fifo_rxd;
              else begin
                eb = exp_byte(m_chk);
                if (int'(fifo_rxd) != eb) begin
                  m_err = 1'b1;
                  if (m_cnt < 255) m_cnt++;
                end
              end
              m_chk++;
            end
            if (rx_exp) m_reads++;
          end
        end
        3: if (!fs) m_ph = 0;
        default: m_ph = 0;
      endcase
      m_pend = rx_exp;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [7:0] b2, input logic [7:0] b3, input bit corrupt);
    logic [7:0] b;
    fq.delete();
    for (int i = 0; i < n; i++) begin
      if (i == 0) b = corrupt ? 8'h00 : 8'h66;
      else if (i == 1) b = 8'hBB;
      else if (i == 2) b = b2;
      else if (i == 3) b = b3;
      else if (i == 5 && corrupt) b = 8'hFF;
      else b = i[7:0];
      fq.push_back(b);
    end
  endtask

  task automatic run_frame(input string tag, input int dlen, input int exp_rx, input int exp_cyc,
                           input int exp_part, input int exp_err, input int exp_cnt);
    int start, cyc;
    data_len = 12'(dlen);
    tick();
    start = rxen_total;
    fs = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!fd && cyc < 2000);
    check({tag, "_fd"}, int'(fd), 1);
    if (exp_cyc >= 0) check({tag, "_fd_latency"}, cyc, exp_cyc);
    repeat (3) tick();
    check({tag, "_fd_hold"}, int'(fd), 1);
    check({tag, "_rxen_pulses"}, rxen_total - start, exp_rx);
    check({tag, "_part"}, int'(part), exp_part);
    check({tag, "_err"}, int'(err), exp_err);
    check({tag, "_err_cnt"}, int'(err_cnt), exp_cnt);
    fs = 1'b0;
    tick();
    tick();
    check({tag, "_fd_clear"}, int'(fd), 0);
  endtask

  initial begin
    int start, cyc;
    rst = 1'b1; fs = 1'b0; data_len = '0; fifo_empty = 1'b1; fifo_rxd = 8'h00;
    #3;
    check("rst_rxen", int'(fifo_rxen), 0);
    check("rst_fd", int'(fd), 0);
    check("rst_part", int'(part), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_so", int'(so), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();

    load(8, 8'h12, 8'h34, 1'b0);
    run_frame("basic", 8, 8, 12, 'h1234, 0, 0);

    load(8, 8'h12, 8'h34, 1'b1);
    run_frame("corrupt", 8, 8, 12, 'h1234, 1, 2);

    load(8, 8'h12, 8'h34, 1'b0);
    tog_en = 1'b1;
    run_frame("toggle", 8, 8, -1, 'h1234, 0, 0);
    tog_en = 1'b0;

    fq.delete();
    run_frame("len0", 0, 0, 2, 'h1234, 0, 0);

    load(128, 8'hAB, 8'hCD, 1'b0);
    run_frame("clip", 300, 128, 132, 'hABCD, 0, 0);
    check("clip_so", int'(so), 'h80);

    // abort after three reads
    load(8, 8'h56, 8'h78, 1'b0);
    data_len = 12'd8;
    tick();
    fd_seen = 1'b0;
    start = rxen_total;
    fs = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (rxen_total - start < 3 && cyc < 200);
    fs = 1'b0;
    repeat (6) tick();
    check("abort_rxen_pulses", rxen_total - start, 3);
    check("abort_fd_seen", int'(fd_seen), 0);
    check("abort_part", int'(part), 'hABCD);
    check("abort_err", int'(err), 0);
    check("abort_so", int'(so), 2);
    fq.delete();
    repeat (2) tick();

    // reset in the middle of a transfer
    load(8, 8'h12, 8'h34, 1'b0);
    data_len = 12'd8;
    tick();
    start = rxen_total;
    fs = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (rxen_total - start < 4 && cyc < 200);
    check("midrst_pre_so", int'(so != 8'h00), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    fs = 1'b0;
    fq.delete();
    #1;
    check("midrst_rxen", int'(fifo_rxen), 0);
    check("midrst_fd", int'(fd), 0);
    check("midrst_part", int'(part), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_err_cnt", int'(err_cnt), 0);
    check("midrst_so", int'(so), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();

    load(8, 8'h12, 8'h34, 1'b0);
    run_frame("after_rst", 8, 8, 12, 'h1234, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
